// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states,
// the latched request record and the alignment rule.
package lsu_pkg;

   localparam int unsigned MEM_BYTES_DEF = 44;
   localparam int unsigned NUM_LANES     = 4;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      RESP = 2'b11
   } state_e;

   typedef struct packed {
      logic        write;
      size_e       size;
      logic        unsgn;
      logic [1:0]  offset;
      logic [31:0] wdata;
   } lsu_req_t;

   // Reserved size is reported as a misalignment.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         SZ_WORD: return (off != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian byte-lane datapath: extracts and extends load data,
// and merges sub-word store data into the word read back from memory.
module byte_lane_unit
   import lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] base_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] store_o
);

   logic [NUM_LANES-1:0][7:0] rd_b;
   logic [NUM_LANES-1:0][7:0] base_b;
   logic [NUM_LANES-1:0][7:0] st_b;
   logic [NUM_LANES-1:0]      lane_en;
   logic [7:0]                byte_sel;
   logic [15:0]               half_sel;

   assign rd_b   = rdata_i;
   assign base_b = base_i;

   always_comb begin
      byte_sel = rd_b[offset_i];
      half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (size_i)
         SZ_BYTE: load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
         default: load_o = rdata_i;
      endcase
   end

   always_comb begin
      case (size_i)
         SZ_BYTE: lane_en = 4'b0001 << offset_i;
         SZ_HALF: lane_en = offset_i[1] ? 4'b1100 : 4'b0011;
         default: lane_en = 4'b1111;
      endcase
   end

   // Each enabled lane takes its byte from the low bits of the store data.
   genvar i;
   generate
      for (i = 0; i < NUM_LANES; i++) begin : g_lane
         logic [7:0] src;
         assign src = (size_i == SZ_BYTE) ? wdata_i[7:0] :
                      (size_i == SZ_HALF) ? wdata_i[8*(i%2) +: 8] :
                                            wdata_i[8*i +: 8];
         assign st_b[i] = lane_en[i] ? src : base_b[i];
      end
   endgenerate

   assign store_o = st_b;

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, sub-word stores via
// read-modify-write, errors answered without touching memory.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        ReqValid_i,
   output logic        ReqReady_o,
   input  logic        ReqWrite_i,
   input  logic [1:0]  ReqSize_i,
   input  logic        ReqUnsigned_i,
   input  logic [31:0] ReqAddr_i,
   input  logic [31:0] ReqWData_i,
   output logic        RespValid_o,
   output logic [31:0] RespData_o,
   output logic        MisalignErr_o,
   output logic        RangeErr_o,
   output logic [31:0] MemAddress_o,
   output logic [31:0] MemWriteData_o,
   output logic        MemWrite_o,
   output logic        MemRead_o,
   input  logic [31:0] MemReadData_i
);

   state_e      state_q, state_d;
   lsu_req_t    req_q;
   logic [31:0] buf_q;
   logic [31:0] rdata_q;
   logic [31:0] addr_q;
   logic        mis_q, rng_q;
   logic        accept, acc_mis, acc_rng;
   logic [31:0] ld_word, st_word;

   assign accept  = ReqValid_i && (state_q == IDLE);
   assign acc_mis = is_misaligned(ReqSize_i, ReqAddr_i[1:0]);
   // Unsigned 32-bit compare on the aligned address; no wrap-around.
   assign acc_rng = ({ReqAddr_i[31:2], 2'b00} > (MEM_BYTES - 32'd4));

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (ReqValid_i) begin
               if (acc_mis || acc_rng)                    state_d = RESP;
               else if (ReqWrite_i && ReqSize_i == SZ_WORD) state_d = WR;
               else                                       state_d = RD;
            end
         end
         RD:      state_d = req_q.write ? WR : RESP;
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes decode straight from state so reset drops them asynchronously.
   always_comb begin
      ReqReady_o  = 1'b0;
      MemRead_o   = 1'b0;
      MemWrite_o  = 1'b0;
      RespValid_o = 1'b0;
      case (state_q)
         IDLE:    ReqReady_o  = 1'b1;
         RD:      MemRead_o   = 1'b1;
         WR:      MemWrite_o  = 1'b1;
         RESP:    RespValid_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         req_q   <= '0;
         buf_q   <= '0;
         rdata_q <= '0;
         addr_q  <= '0;
         mis_q   <= 1'b0;
         rng_q   <= 1'b0;
      end else begin
         if (accept) begin
            req_q <= '{write:  ReqWrite_i,
                       size:   size_e'(ReqSize_i),
                       unsgn:  ReqUnsigned_i,
                       offset: ReqAddr_i[1:0],
                       wdata:  ReqWData_i};
            mis_q <= acc_mis;
            rng_q <= acc_rng & ~acc_mis;
            if (!(acc_mis || acc_rng)) addr_q <= {ReqAddr_i[31:2], 2'b00};
         end
         if (state_q == RD) begin
            buf_q <= MemReadData_i;
            if (!req_q.write) rdata_q <= ld_word;
         end
      end
   end

   byte_lane_unit u_lanes (
      .size_i     (req_q.size),
      .unsigned_i (req_q.unsgn),
      .offset_i   (req_q.offset),
      .rdata_i    (MemReadData_i),
      .base_i     (buf_q),
      .wdata_i    (req_q.wdata),
      .load_o     (ld_word),
      .store_o    (st_word)
   );

   assign MemAddress_o   = addr_q;
   assign MemWriteData_o = st_word;
   assign RespData_o     = rdata_q;
   assign MisalignErr_o  = mis_q & (state_q == RESP);
   assign RangeErr_o     = rng_q & (state_q == RESP);

endmodule
